// File: rtl/vdp_super_palette.sv
// rtl/vdp_super_palette.sv - palette index to 24-bit RGB lookup with CPU write port and grey-ramp init
//
// Purpose:
//    Last stage of the super-res/super-mid pixel pipeline. Every dot clock an
//    8-bit palette index is looked up in a 256-entry RGB RAM. The result leaves
//    the block exactly two clocks after the index is sampled. After reset the
//    RAM is swept to a grey ramp (entry i = {i,i,i}). Once that sweep is done,
//    the CPU may rewrite entries as auto-incrementing R,G,B byte triples.
//
// Ports:
//    clk               dot clock, rising edge
//    reset             asynchronous, active-high
//    vdp_super_i       super modes enabled; low blanks the pixel
//    palette_addr_i    pixel palette index, sampled every clock
//    display_active_i  visible area; low blanks the pixel
//    wr_index_load_i   load wr_index_i into the write pointer, restart byte phase
//    wr_index_i        start entry for CPU writes
//    wr_strobe_i       wr_data_i carries the next R/G/B byte
//    wr_data_i         CPU colour byte
//    pal_r_o/g_o/b_o   registered colour outputs
//    init_busy_o       high while the grey-ramp sweep runs
//    wr_ptr_o          current CPU write entry
module vdp_super_palette #(
   parameter int ENTRIES = 256,
   parameter int CH_BITS = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       vdp_super_i,
   input  logic [$clog2(ENTRIES)-1:0] palette_addr_i,
   input  logic                       display_active_i,
   input  logic                       wr_index_load_i,
   input  logic [$clog2(ENTRIES)-1:0] wr_index_i,
   input  logic                       wr_strobe_i,
   input  logic [CH_BITS-1:0]         wr_data_i,
   output logic [CH_BITS-1:0]         pal_r_o,
   output logic [CH_BITS-1:0]         pal_g_o,
   output logic [CH_BITS-1:0]         pal_b_o,
   output logic                       init_busy_o,
   output logic [$clog2(ENTRIES)-1:0] wr_ptr_o
);

   localparam int IW   = $clog2(ENTRIES);
   localparam int RGBW = 3 * CH_BITS;
   localparam logic [IW-1:0] LAST_ENTRY = IW'(ENTRIES - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state_q;
   logic [IW-1:0]      init_cnt_q;
   logic               init_busy_q;
   logic [IW-1:0]      wr_ptr_q;
   logic [1:0]         phase_q;
   logic [CH_BITS-1:0] stage_r_q;
   logic [CH_BITS-1:0] stage_g_q;

   logic [RGBW-1:0]    mem [ENTRIES];
   logic               ram_we_d;
   logic [IW-1:0]      ram_waddr_d;
   logic [RGBW-1:0]    ram_wdata_d;

   logic [IW-1:0]      addr_q;
   logic [RGBW-1:0]    rd_q;
   logic [RGBW-1:0]    out_q;
   logic [1:0]         active_q;
   logic [1:0]         super_q;

   // Control: grey-ramp sweep, then the CPU triple assembler.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         init_busy_q <= 1'b1;
         wr_ptr_q    <= '0;
         phase_q     <= 2'd0;
         stage_r_q   <= '0;
         stage_g_q   <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == LAST_ENTRY) begin
                  state_q     <= ST_RUN;
                  init_busy_q <= 1'b0;
               end
            end
            ST_RUN: begin
               // A load in the same clock as a strobe wins; the strobe is dropped.
               if (wr_index_load_i) begin
                  wr_ptr_q <= wr_index_i;
                  phase_q  <= 2'd0;
               end else if (wr_strobe_i) begin
                  case (phase_q)
                     2'd0: begin
                        stage_r_q <= wr_data_i;
                        phase_q   <= 2'd1;
                     end
                     2'd1: begin
                        stage_g_q <= wr_data_i;
                        phase_q   <= 2'd2;
                     end
                     default: begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        phase_q  <= 2'd0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   // Single RAM write port shared between the init sweep and the CPU.
   always_comb begin
      ram_we_d    = 1'b0;
      ram_waddr_d = init_cnt_q;
      ram_wdata_d = {3{CH_BITS'(init_cnt_q)}};
      if (state_q == ST_INIT) begin
         ram_we_d = 1'b1;
      end else if (!wr_index_load_i && wr_strobe_i && phase_q == 2'd2) begin
         ram_we_d    = 1'b1;
         ram_waddr_d = wr_ptr_q;
         ram_wdata_d = {stage_r_q, stage_g_q, wr_data_i};
      end
   end

   // Non-blocking read and write on the same edge give read-first behaviour.
   always_ff @(posedge clk) begin
      if (ram_we_d) begin
         mem[ram_waddr_d] <= ram_wdata_d;
      end
      rd_q <= mem[addr_q];
   end

   // Pixel pipeline: index -> RAM read -> gated output, blank flags ride alongside.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         active_q <= 2'b00;
         super_q  <= 2'b00;
         out_q    <= '0;
      end else begin
         addr_q   <= palette_addr_i;
         active_q <= {active_q[0], display_active_i};
         super_q  <= {super_q[0], vdp_super_i};
         // The RAM holds garbage until the sweep ends, so outputs stay dark in INIT.
         if (state_q == ST_RUN && active_q[1] && super_q[1]) begin
            out_q <= rd_q;
         end else begin
            out_q <= '0;
         end
      end
   end

   assign pal_r_o     = out_q[RGBW-1 -: CH_BITS];
   assign pal_g_o     = out_q[2*CH_BITS-1 -: CH_BITS];
   assign pal_b_o     = out_q[CH_BITS-1:0];
   assign init_busy_o = init_busy_q;
   assign wr_ptr_o    = wr_ptr_q;

endmodule

// File: tb/tb_vdp_super_palette.sv
// tb/tb_vdp_super_palette.sv - randomized self-checking bench for vdp_super_palette
module tb_vdp_super_palette;

   logic       clk;
   logic       reset;
   logic       vdp_super_i;
   logic [7:0] palette_addr_i;
   logic       display_active_i;
   logic       wr_index_load_i;
   logic [7:0] wr_index_i;
   logic       wr_strobe_i;
   logic [7:0] wr_data_i;
   logic [7:0] pal_r_o;
   logic [7:0] pal_g_o;
   logic [7:0] pal_b_o;
   logic       init_busy_o;
   logic [7:0] wr_ptr_o;

   logic [23:0] rgb;
   assign rgb = {pal_r_o, pal_g_o, pal_b_o};

   // Reference: palette contents, write pointer, bytes of the unfinished triple,
   // and expected pixels still in flight.
   logic [23:0] m_pal [256];
   logic [7:0]  m_ptr;
   logic [7:0]  m_stage [$];
   logic [23:0] exp_q [$];
   logic        got_chk;
   logic [23:0] got_exp;

   int pass_cnt  = 0;
   int total_cnt = 0;

   vdp_super_palette dut (
      .clk              (clk),
      .reset            (reset),
      .vdp_super_i      (vdp_super_i),
      .palette_addr_i   (palette_addr_i),
      .display_active_i (display_active_i),
      .wr_index_load_i  (wr_index_load_i),
      .wr_index_i       (wr_index_i),
      .wr_strobe_i      (wr_strobe_i),
      .wr_data_i        (wr_data_i),
      .pal_r_o          (pal_r_o),
      .pal_g_o          (pal_g_o),
      .pal_b_o          (pal_b_o),
      .init_busy_o      (init_busy_o),
      .wr_ptr_o         (wr_ptr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_pal[i] = {3{8'(i)}};
      m_ptr = 8'h00;
      m_stage.delete();
   endtask

   task automatic flush();
      exp_q.delete();
   endtask

   // One dot clock. The model applies this clock's CPU write before computing the
   // pixel, because a write committed at this edge is visible to the RAM read on
   // the next edge; a write on that next edge is not (read-first).
   task automatic step(input logic [7:0] a, input logic da, input logic sup,
                       input logic ld, input logic [7:0] idx,
                       input logic stb, input logic [7:0] dat);
      palette_addr_i   = a;
      display_active_i = da;
      vdp_super_i      = sup;
      wr_index_load_i  = ld;
      wr_index_i       = idx;
      wr_strobe_i      = stb;
      wr_data_i        = dat;
      if (ld) begin
         m_ptr = idx;
         m_stage.delete();
      end else if (stb) begin
         m_stage.push_back(dat);
         if (m_stage.size() == 3) begin
            m_pal[m_ptr] = {m_stage[0], m_stage[1], m_stage[2]};
            m_ptr = m_ptr + 8'd1;
            m_stage.delete();
         end
      end
      exp_q.push_back((da && sup) ? m_pal[a] : 24'h0);
      @(posedge clk);
      #1;
      wr_index_load_i = 1'b0;
      wr_strobe_i     = 1'b0;
      got_chk = 1'b0;
      got_exp = 24'h0;
      if (exp_q.size() == 3) begin
         got_exp = exp_q.pop_front();
         got_chk = 1'b1;
      end
   endtask

   task automatic idle();             step(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00); endtask
   task automatic rd(input logic [7:0] a);   step(a, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00); endtask
   task automatic ld(input logic [7:0] i);   step(8'h00, 1'b0, 1'b0, 1'b1, i, 1'b0, 8'h00); endtask
   task automatic stb(input logic [7:0] d);  step(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, d); endtask

   task automatic test_reset();
      int n;
      int bad;
      reset = 1'b1;
      vdp_super_i = 1'b0; palette_addr_i = 8'h00; display_active_i = 1'b0;
      wr_index_load_i = 1'b0; wr_index_i = 8'h00; wr_strobe_i = 1'b0; wr_data_i = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (rgb !== 24'h0 || init_busy_o !== 1'b1 || wr_ptr_o !== 8'h00)
         $display("FAIL reset_state: rgb=%h busy=%b ptr=%h, want 000000 1 00", rgb, init_busy_o, wr_ptr_o);
      else pass_cnt++;
      reset = 1'b0;
      model_reset();
      n = 0;
      bad = 0;
      // CPU traffic during the sweep must be ignored and the outputs stay dark.
      while (init_busy_o === 1'b1 && n < 400) begin
         palette_addr_i   = 8'($urandom);
         display_active_i = 1'b1;
         vdp_super_i      = 1'b1;
         wr_strobe_i      = 1'($urandom_range(0, 1));
         wr_index_load_i  = 1'($urandom_range(0, 1));
         wr_index_i       = 8'($urandom);
         wr_data_i        = 8'($urandom);
         @(posedge clk);
         #1;
         n++;
         if (rgb !== 24'h0) bad++;
      end
      wr_strobe_i = 1'b0;
      wr_index_load_i = 1'b0;
      total_cnt++;
      if (n !== 256) $display("FAIL init_length: busy for %0d clks, want 256", n);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL init_dark: %0d non-zero pixels during init, want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (wr_ptr_o !== 8'h00) $display("FAIL init_ptr: wr_ptr=%h, want 00", wr_ptr_o);
      else pass_cnt++;
   endtask

   task automatic test_grey_read();
      flush();
      rd(8'h80);
      idle();
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'h808080) $display("FAIL grey_0x80: rgb=%h, want 808080", rgb);
      else pass_cnt++;
   endtask

   task automatic test_cpu_write();
      ld(8'h10);
      foreach (m_pal[i]) if (i < 6) stb(8'(8'h11 * (i + 1)));
      total_cnt++;
      if (wr_ptr_o !== 8'h12) $display("FAIL write_ptr: wr_ptr=%h, want 12", wr_ptr_o);
      else pass_cnt++;
      flush();
      rd(8'h10);
      rd(8'h11);
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'h112233) $display("FAIL write_entry10: rgb=%h, want 112233", rgb);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'h445566) $display("FAIL write_entry11: rgb=%h, want 445566", rgb);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [7:0] b [6];
      ld(8'hFF);
      for (int i = 0; i < 6; i++) begin
         b[i] = 8'($urandom);
         stb(b[i]);
      end
      total_cnt++;
      if (wr_ptr_o !== 8'h01) $display("FAIL wrap_ptr: wr_ptr=%h, want 01", wr_ptr_o);
      else pass_cnt++;
      flush();
      rd(8'hFF);
      rd(8'h00);
      idle();
      total_cnt++;
      if (!got_chk || rgb !== {b[0], b[1], b[2]}) $display("FAIL wrap_entryFF: rgb=%h, want %h", rgb, {b[0], b[1], b[2]});
      else pass_cnt++;
      idle();
      total_cnt++;
      if (!got_chk || rgb !== {b[3], b[4], b[5]}) $display("FAIL wrap_entry00: rgb=%h, want %h", rgb, {b[3], b[4], b[5]});
      else pass_cnt++;
   endtask

   task automatic test_load_over_strobe();
      int bad;
      logic [23:0] e5;
      stb(8'hAA);
      stb(8'hBB);
      step(8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'hCC);
      stb(8'hDD);
      stb(8'hEE);
      stb(8'hFF);
      total_cnt++;
      if (wr_ptr_o !== 8'h06) $display("FAIL load_wins_ptr: wr_ptr=%h, want 06", wr_ptr_o);
      else pass_cnt++;
      flush();
      bad = 0;
      e5 = 24'hx;
      for (int a = 0; a < 258; a++) begin
         step(8'(a), a < 256, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
         if (got_chk) begin
            if (rgb !== got_exp) bad++;
            if (a - 2 == 5) e5 = rgb;
         end
      end
      total_cnt++;
      if (e5 !== 24'hDDEEFF) $display("FAIL load_wins_entry05: rgb=%h, want ddeeff", e5);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL palette_sweep: %0d entries differ, want 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_ramp_blank();
      int bad;
      flush();
      bad = 0;
      for (int c = 0; c < 258; c++) begin
         step(8'(c), c < 100, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
         if (got_chk) begin
            if (rgb !== got_exp) bad++;
            if (c - 2 == 99) begin
               total_cnt++;
               if (rgb !== 24'h636363) $display("FAIL blank_edge_last_lit: rgb=%h, want 636363", rgb);
               else pass_cnt++;
            end
            if (c - 2 == 100) begin
               total_cnt++;
               if (rgb !== 24'h000000) $display("FAIL blank_edge_first_dark: rgb=%h, want 000000", rgb);
               else pass_cnt++;
            end
         end
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL ramp_stream: %0d pixels differ, want 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_collision();
      flush();
      ld(8'h40);
      stb(8'h01);
      step(8'h40, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
      step(8'h40, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03);
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'h404040) $display("FAIL collision_old: rgb=%h, want 404040", rgb);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'h010203) $display("FAIL collision_new: rgb=%h, want 010203", rgb);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] a;
      flush();
      for (int c = 0; c < 800; c++) begin
         a = ($urandom_range(0, 3) == 0) ? m_ptr : 8'($urandom);
         step(a, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 15) == 0, 8'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom));
         total_cnt++;
         if (wr_ptr_o !== m_ptr) $display("FAIL random_ptr: cycle %0d wr_ptr=%h, want %h", c, wr_ptr_o, m_ptr);
         else pass_cnt++;
         if (got_chk) begin
            total_cnt++;
            if (rgb !== got_exp) $display("FAIL random_pixel: cycle %0d rgb=%h, want %h", c, rgb, got_exp);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int bad;
      ld(8'h20);
      stb(8'h99);
      stb(8'h98);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      repeat (50) @(posedge clk);
      #1;
      total_cnt++;
      if (init_busy_o !== 1'b1) $display("FAIL mid_init_busy: busy=%b, want 1", init_busy_o);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n = 0;
      while (init_busy_o === 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      total_cnt++;
      if (n !== 256) $display("FAIL reinit_length: busy for %0d clks, want 256", n);
      else pass_cnt++;
      flush();
      bad = 0;
      for (int a = 0; a < 258; a++) begin
         step(8'(a), a < 256, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
         if (got_chk && rgb !== got_exp) bad++;
         if (got_chk && a - 2 == 8'h20) begin
            total_cnt++;
            if (rgb !== 24'h202020) $display("FAIL reinit_entry20: rgb=%h, want 202020", rgb);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL reinit_sweep: %0d entries not grey, want 0", bad);
      else pass_cnt++;
      stb(8'hAB);
      stb(8'hCD);
      stb(8'hEF);
      total_cnt++;
      if (wr_ptr_o !== 8'h01) $display("FAIL partial_lost_ptr: wr_ptr=%h, want 01", wr_ptr_o);
      else pass_cnt++;
      flush();
      rd(8'h00);
      idle();
      idle();
      total_cnt++;
      if (!got_chk || rgb !== 24'hABCDEF) $display("FAIL partial_lost_entry00: rgb=%h, want abcdef", rgb);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_grey_read();
      test_cpu_write();
      test_wrap();
      test_load_over_strobe();
      test_ramp_blank();
      test_collision();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
